serial_ripple_subtractor: RTL and testbench
===========================================

// Module: serial_ripple_subtractor
// PURPOSE
//   Bit-serial W-bit unsigned subtractor: D = A - B, one full-subtractor bit per clock,
//   LSB first, borrow held in a flop between cycles. Complements the 8-bit ripple
//   adder as the arithmetic's reverse direction, trading W cycles of latency for one
//   full-subtractor cell. Sits between valid/ready producer and consumer stages.
// PARAMETERS
//   W        8    operand/result width in bits; legal range W >= 2
//   CNT_W    $clog2(W)  bit-counter width (derived, not overridden)
// PORTS
//   clk        in   1   clock, all state updates on rising edge
//   rst        in   1   asynchronous, active-high reset
//   in_valid   in   1   operands a/b valid
//   in_ready   out  1   block can accept operands (high only in IDLE)
//   a          in   W   minuend, sampled on accept
//   b          in   W   subtrahend, sampled on accept
//   out_valid  out  1   result d/bout valid (high only in DONE)
//   out_ready  in   1   consumer accepts result
//   d          out  W   difference, (a - b) mod 2^W
//   bout       out  1   final borrow; 1 iff a < b (unsigned)
//   ovf        out  1   signed overflow; port exists only with SUB_OVF_EN
// BEHAVIOUR
//   - One clock clk; reset rst is asynchronous, active-high. Reset: state=IDLE,
//     in_ready=1, out_valid=0, d=0, bout=0, ovf=0, borrow flop=0, counter=0.
//   - FSM: IDLE -> RUN on in_valid&&in_ready (accept edge): load a/b shift regs,
//     borrow=0, cnt=0. RUN: each edge processes bit cnt:
//       dk = ak ^ bk ^ br;  br' = (~ak & bk) | (~(ak ^ bk) & br)
//     dk shifts into d from MSB side; a/b shift right. RUN -> DONE on edge with
//     cnt==W-1; bout latched = final br'. DONE -> IDLE on out_ready.
//   - Latency: out_valid rises exactly W rising edges after the accept edge.
//     Throughput: one operation per W+2 cycles minimum (accept, W RUN, DONE hand-off).
//   - in_ready=1 only in IDLE; in_valid in RUN/DONE ignored, operands not sampled.
//   - out_valid=1 only in DONE; d/bout stable while out_valid && !out_ready.
//     out_ready outside DONE ignored. out_ready may be held high: DONE lasts 1 cycle.
//   - d and bout are registers; d shows partial shift contents during RUN
//     (don't-care unless out_valid). bout/ovf update only on DONE entry.
//   - Boundaries: a==b -> d=0,bout=0; a=0,b=2^W-1 -> d=1,bout=1; wrap is mod 2^W.
//   - rst asserted in RUN or DONE aborts the operation; result discarded; block
//     returns to reset values immediately (asynchronous), first accept possible on
//     first edge after rst deasserts.
//   - No combinational path from in_valid to in_ready or out_ready to out_valid.
// CONFIGURATION
//   SUB_OVF_EN defined: port ovf present; latched on DONE entry as
//     (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]) using the originally accepted a/b
//     (stash a[W-1], b[W-1] at accept). Reset 0; held with d during DONE.
//   SUB_OVF_EN undefined: no ovf port, no sign-bit flops; all else identical.
// TESTING
//   1. W=8, a=200,b=55, out_ready=1 -> out_valid exactly 8 edges post-accept, d=145, bout=0.
//   2. a=5,b=10 -> d=251 (0xFB), bout=1; a=0,b=0 -> d=0,bout=0; a=0,b=255 -> d=1,bout=1.
//   3. SUB_OVF_EN: a=0x80,b=0x01 -> d=0x7F, ovf=1; a=0x7F,b=0xFF -> d=0x80, ovf=1; a=3,b=1 -> ovf=0.
//   4. out_ready low 5 cycles in DONE -> d/bout/out_valid stable, in_ready=0, in_valid pulses ignored.
//   5. rst pulsed at RUN cnt=3 -> out_valid=0,in_ready=1,d=0 same cycle; next op a=9,b=4 -> d=5.
//   6. Exhaustive: all 65536 {a,b} pairs, back-to-back in_valid -> d==(a-b)&0xFF, bout==(a<b).

Source files
------------

// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor: bit-serial W-bit unsigned subtractor, LSB first, valid/ready on both sides.
// Optional signed-overflow output when SUB_OVF_EN is defined.
module serial_ripple_subtractor #(
   parameter int W = 8,
   localparam int CNT_W = $clog2(W)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] d,
   output logic         bout
`ifdef SUB_OVF_EN
   ,
   output logic         ovf
`endif
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_n;
   logic [W-1:0] sa, sb;
   logic [CNT_W-1:0] cnt;
   logic br, dk, br_n, last, accept;
   assign accept = (state == IDLE) && in_valid;
   assign last = cnt == CNT_W'(W - 1);
   assign dk = sa[0] ^ sb[0] ^ br;
   assign br_n = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
   assign in_ready = state == IDLE;
   assign out_valid = state == DONE;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      if (state == IDLE) state_n = in_valid ? RUN : IDLE;
      else if (state == RUN) state_n = last ? DONE : RUN;
      else state_n = out_ready ? IDLE : DONE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sa <= '0;
         sb <= '0;
         d <= '0;
         br <= 1'b0;
         bout <= 1'b0;
         cnt <= '0;
      end else if (accept) begin
         sa <= a;
         sb <= b;
         br <= 1'b0;
         cnt <= '0;
      end else if (state == RUN) begin
         d <= {dk, d[W-1:1]};
         sa <= sa >> 1;
         sb <= sb >> 1;
         br <= br_n;
         cnt <= cnt + 1'b1;
         if (last) bout <= br_n;
      end
`ifdef SUB_OVF_EN
   // sign bits of the accepted operands; dk on the last RUN edge is the result MSB
   logic a_msb, b_msb;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf <= 1'b0;
      end else if (accept) begin
         a_msb <= a[W-1];
         b_msb <= b[W-1];
      end else if (state == RUN && last)
         ovf <= (a_msb != b_msb) && (dk != a_msb);
`endif
endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// tb_serial_ripple_subtractor: scoreboard bench for serial_ripple_subtractor (W=8).
// Define SUB_OVF_EN for both files to exercise the overflow output.
module tb_serial_ripple_subtractor;
   localparam int W = 8;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
   logic [W-1:0] a = '0, b = '0, d;
   logic in_ready, out_valid, bout;
   int total = 0, bad = 0;
   logic [9:0] q[$];
`ifdef SUB_OVF_EN
   logic ovf;
`endif
   serial_ripple_subtractor #(.W(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .d(d), .bout(bout)
`ifdef SUB_OVF_EN
      , .ovf(ovf)
`endif
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic logic [9:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] r;
      r = x - y;
      return {x < y, (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]), r};
   endfunction
   // one result popped per completed output handshake
   always @(negedge clk)
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) check("unexpected_out", 1, 0);
         else begin
            logic [9:0] e;
            e = q.pop_front();
            check("d", d, e[7:0]);
            check("bout", bout, e[9]);
`ifdef SUB_OVF_EN
            check("ovf", ovf, e[8]);
`endif
         end
      end
   // leaves in_valid high so consecutive calls run back-to-back
   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
      int n = 0;
      a = x;
      b = y;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         check("accept_timeout", 0, 1);
         return;
      end
      q.push_back(model(x, y));
      @(posedge clk);
      #1;
   endtask
   initial begin
      int n;
      #2;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_d", d, 0);
      check("rst_bout", bout, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      send(200, 55);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1 n++;
      end
      check("latency", n, W);
      send(5, 10);
      send(0, 0);
      send(0, 255);
      send(8'h80, 8'h01);
      send(8'h7F, 8'hFF);
      send(3, 1);
      send(255, 0);
      send(8'hAA, 8'hAA);
      in_valid = 1'b0;
      repeat (12) @(posedge clk);
      #1 out_ready = 1'b0;
      send(5, 10);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1 n++;
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         a = 8'h33;
         b = 8'h11;
         @(negedge clk);
         check("stall_valid", out_valid, 1);
         check("stall_in_ready", in_ready, 0);
         check("stall_d", d, 251);
         check("stall_bout", bout, 1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("stall_drained", q.size(), 0);
      check("stall_idle", in_ready, 1);
      send(100, 7);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      q.delete();
      check("abort_out_valid", out_valid, 0);
      check("abort_in_ready", in_ready, 1);
      check("abort_d", d, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      send(9, 4);
      for (int i = 0; i < 2000; i++) begin
         logic [W-1:0] x, y;
         x = W'($urandom);
         y = (i % 16 == 0) ? x : W'($urandom);
         send(x, y);
      end
      in_valid = 1'b0;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      check("drain_final", q.size(), 0);
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
